ppg_slot_sequencer: RTL and testbench
=====================================

# ppg_slot_sequencer

Operation-mode time-division sequencer for the pulse-oximeter front end. It cycles the RED LED, IR LED and a dark (ambient) slot, loads the per-channel DC compensation and PGA gain calibrated by the setting-search controller, and blanks the analog settling interval. It then averages a window of ADC samples per slot and publishes RED/IR/ambient results with one-cycle valid strobes. It sits between the calibration controller (source of settings and enable) and the downstream SpO2 computation.

## Interface
- SLOT_CYCLES, 10: CLK cycles per slot (RED, IR, DARK each).
- SETTLE_CYCLES, 4: cycles ignored at the start of each slot (LED/PGA/DC settling).
- AVG_LOG2, 2: log2 of samples averaged per slot (N = 2^AVG_LOG2). Legal only if SETTLE_CYCLES + N <= SLOT_CYCLES - 1.
- CLK  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  run sequencing; typically the calibration-complete flag.
- ADC  input  8  ADC sample, valid every cycle.
- RED_DC_Comp / IR_DC_Comp  input  7  calibrated DC compensation codes.
- RED_PGA / IR_PGA  input  4  calibrated PGA gain codes.
- LED_RED, LED_IR  output  1  LED enables; never both 1.
- DC_Comp  output  7  DC compensation code to the analog front end.
- PGA_Gain  output  4  PGA gain code.
- RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value  output  8  averaged slot results.
- red_valid, ir_valid, amb_valid  output  1  one-cycle strobe when the matching value updates.
- busy  output  1  high in any non-IDLE state.

## Operation
- States: IDLE, RED, IR, DARK. Slot order is RED -> IR -> DARK -> RED.
- IDLE: LEDs off. When enable=1, the next state is RED.
- Slot entry (the cycle the state changes):
  - slot counter cnt <= 0 and accumulator <= 0.
  - Settings are captured from the inputs at this edge only. Mid-slot input changes take effect at the next entry of that slot.
  - RED: LED_RED=1, LED_IR=0, DC_Comp=RED_DC_Comp, PGA_Gain=RED_PGA.
  - IR: LED_RED=0, LED_IR=1, DC_Comp=IR_DC_Comp, PGA_Gain=IR_PGA.
  - DARK: both LEDs 0, DC_Comp=IR_DC_Comp, PGA_Gain=IR_PGA (ambient is measured through the IR chain).
- Sampling:
  - ADC is added to the accumulator (width 8+AVG_LOG2, cannot overflow) when SETTLE_CYCLES <= cnt < SETTLE_CYCLES+N.
  - Samples taken while cnt < SETTLE_CYCLES are discarded.
- Result: at cnt == SETTLE_CYCLES+N, the slot's value register <= accumulator >> AVG_LOG2 (truncating), and its valid strobe is 1 for that cycle only.
- Slot end: at cnt == SLOT_CYCLES-1, the next edge enters the next slot.
  - If enable=0 at that point, go to IDLE instead.
  - enable is sampled only at slot end and in IDLE; deassertion mid-slot completes the current slot and its result.
- Result values hold until overwritten. PGA_Gain and DC_Comp hold their last values in IDLE.

## Timing
- Reset values: LEDs 0, DC_Comp 0, PGA_Gain 0, all *_ADC_Value 0, all valids 0, busy 0, state IDLE, cnt 0, accumulator 0.
- Reset asserted mid-slot: immediate return to reset values, with no partial result or strobe.
- Edge 0 is the posedge that samples enable=1 in IDLE. After edge 0: RED entered, cnt=0, busy=1.
- With default parameters:
  - Samples are taken at cnt 4..7 of each slot.
  - The value and valid strobe appear in the cycle with cnt=8.
  - Slot period is 10 cycles; full frame is 30 cycles.
- Latency: the result is registered 1 cycle after the last sample.
- Break-before-make: LED changes occur on the same edge as state entry. No cycle exists where both LEDs are 1.
- At most one valid strobe is high in any cycle.
- Counter wrap: cnt never exceeds SLOT_CYCLES-1 and resets at every slot entry.

## Test plan
- Constant inputs: ADC=200 in RED, 90 in IR, 12 in DARK; enable held high -> RED_ADC_Value=200, IR_ADC_Value=90, AMB_ADC_Value=12. Strobes at cnt=8, 10 cycles apart, repeating every 30 cycles. LEDs never both 1.
- Averaging and truncation: RED-slot ADC=10, 20, 30, 41 at cnt 4..7 -> RED_ADC_Value=25 (sum 101 >> 2).
- Settle blanking: ADC=255 at cnt 0..3 and 100 at cnt 4..9 in IR -> IR_ADC_Value=100.
- Settings capture: RED_DC_Comp changes 60 -> 70 at RED cnt=5 -> DC_Comp stays 60 until the next RED entry, then becomes 70. PGA_Gain equals IR_PGA in both IR and DARK.
- Enable drop: enable falls at IR cnt=3 -> ir_valid still pulses at cnt=8, IDLE is entered after cnt=9, DARK is never entered, busy falls, LEDs are 0.
- Reset mid-slot: rst_n low at RED cnt=6 -> all outputs return to reset values asynchronously with no red_valid. After release with enable=1, sequencing restarts at RED with cnt=0.

Source files
------------

// File: rtl/ppg_slot_sequencer.sv
// RED / IR / DARK time-division sequencer: loads per-channel front-end settings on
// slot entry, blanks the settling interval and averages 2^AVG_LOG2 ADC samples per slot.
module ppg_slot_sequencer #(
    parameter int SLOT_CYCLES   = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int AVG_LOG2      = 2
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] ADC,
    input  logic [6:0] RED_DC_Comp,
    input  logic [6:0] IR_DC_Comp,
    input  logic [3:0] RED_PGA,
    input  logic [3:0] IR_PGA,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] AMB_ADC_Value,
    output logic       red_valid,
    output logic       ir_valid,
    output logic       amb_valid,
    output logic       busy
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int AW = 8 + AVG_LOG2;

    localparam logic [CW-1:0] SMP_FIRST = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] SMP_LAST  = CW'(SETTLE_CYCLES + N - 1);
    localparam logic [CW-1:0] CNT_END   = CW'(SLOT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RED, IR, DARK} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   acc_q, acc_d;
    logic            led_red_q, led_ir_q;
    logic [6:0]      dc_q;
    logic [3:0]      pga_q;
    logic [7:0]      red_val_q, ir_val_q, amb_val_q;
    logic            red_vld_q, ir_vld_q, amb_vld_q;
    logic            slot_end, sample_en, last_smp, entry;

    always_comb begin
        slot_end  = (state_q != IDLE) && (cnt_q == CNT_END);
        sample_en = (state_q != IDLE) && (cnt_q >= SMP_FIRST) && (cnt_q <= SMP_LAST);
        last_smp  = (state_q != IDLE) && (cnt_q == SMP_LAST);
        acc_d     = sample_en ? acc_q + AW'(ADC) : acc_q;
        state_d   = state_q;
        case (state_q)
            IDLE:    if (enable)   state_d = RED;
            RED:     if (slot_end) state_d = enable ? IR   : IDLE;
            IR:      if (slot_end) state_d = enable ? DARK : IDLE;
            DARK:    if (slot_end) state_d = enable ? RED  : IDLE;
            default: state_d = IDLE;
        endcase
        entry = (state_d != state_q) && (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            led_red_q <= 1'b0;
            led_ir_q  <= 1'b0;
            dc_q      <= '0;
            pga_q     <= '0;
            red_val_q <= '0;
            ir_val_q  <= '0;
            amb_val_q <= '0;
            red_vld_q <= 1'b0;
            ir_vld_q  <= 1'b0;
            amb_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            red_vld_q <= 1'b0;
            ir_vld_q  <= 1'b0;
            amb_vld_q <= 1'b0;
            if (state_d == IDLE) begin
                // DC/PGA intentionally keep their last codes while idle
                cnt_q     <= '0;
                acc_q     <= '0;
                led_red_q <= 1'b0;
                led_ir_q  <= 1'b0;
            end else if (entry) begin
                cnt_q <= '0;
                acc_q <= '0;
                case (state_d)
                    RED: begin
                        led_red_q <= 1'b1;
                        led_ir_q  <= 1'b0;
                        dc_q      <= RED_DC_Comp;
                        pga_q     <= RED_PGA;
                    end
                    IR: begin
                        led_red_q <= 1'b0;
                        led_ir_q  <= 1'b1;
                        dc_q      <= IR_DC_Comp;
                        pga_q     <= IR_PGA;
                    end
                    default: begin
                        // ambient is measured through the IR chain
                        led_red_q <= 1'b0;
                        led_ir_q  <= 1'b0;
                        dc_q      <= IR_DC_Comp;
                        pga_q     <= IR_PGA;
                    end
                endcase
            end else begin
                cnt_q <= cnt_q + CW'(1);
                acc_q <= acc_d;
                // result includes the sample arriving on this edge, so it lands at cnt=SETTLE+N
                if (last_smp) begin
                    case (state_q)
                        RED: begin
                            red_val_q <= acc_d[AW-1:AVG_LOG2];
                            red_vld_q <= 1'b1;
                        end
                        IR: begin
                            ir_val_q <= acc_d[AW-1:AVG_LOG2];
                            ir_vld_q <= 1'b1;
                        end
                        default: begin
                            amb_val_q <= acc_d[AW-1:AVG_LOG2];
                            amb_vld_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign LED_RED       = led_red_q;
    assign LED_IR        = led_ir_q;
    assign DC_Comp       = dc_q;
    assign PGA_Gain      = pga_q;
    assign RED_ADC_Value = red_val_q;
    assign IR_ADC_Value  = ir_val_q;
    assign AMB_ADC_Value = amb_val_q;
    assign red_valid     = red_vld_q;
    assign ir_valid      = ir_vld_q;
    assign amb_valid     = amb_vld_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ppg_slot_sequencer.sv
// Bench for ppg_slot_sequencer: per-slot vector table plus hand sequences for
// settings capture, enable drop and mid-slot reset; results checked via a scoreboard.
module tb_ppg_slot_sequencer;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable;
    logic [7:0] ADC;
    logic [6:0] RED_DC_Comp, IR_DC_Comp;
    logic [3:0] RED_PGA, IR_PGA;
    logic       LED_RED, LED_IR;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic [7:0] RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value;
    logic       red_valid, ir_valid, amb_valid, busy;

    ppg_slot_sequencer dut (
        .CLK(CLK), .rst_n(rst_n), .enable(enable), .ADC(ADC),
        .RED_DC_Comp(RED_DC_Comp), .IR_DC_Comp(IR_DC_Comp),
        .RED_PGA(RED_PGA), .IR_PGA(IR_PGA),
        .LED_RED(LED_RED), .LED_IR(LED_IR), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
        .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value), .AMB_ADC_Value(AMB_ADC_Value),
        .red_valid(red_valid), .ir_valid(ir_valid), .amb_valid(amb_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         slot;
        logic [7:0] val;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [7:0]      pre;
        logic [3:0][7:0] smp;
        logic [7:0]      post;
        logic [7:0]      exp;
    } vec_t;
    vec_t vecs[9];

    function automatic vec_t mk(input int pre, input int a, input int b, input int c,
                                input int d, input int post, input int exp);
        vec_t v;
        v.pre    = 8'(pre);
        v.smp[0] = 8'(a);
        v.smp[1] = 8'(b);
        v.smp[2] = 8'(c);
        v.smp[3] = 8'(d);
        v.post   = 8'(post);
        v.exp    = 8'(exp);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // strobe monitor, run once per cycle on the falling edge
    task automatic mon();
        logic [2:0] v;
        int         k;
        sb_t        e;
        v = {red_valid, ir_valid, amb_valid};
        chk("led_excl", 32'(LED_RED & LED_IR), 32'd0);
        if (v != 3'b000) begin
            chk("one_strobe", 32'($countones(v)), 32'd1);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got valid=%b want none at %0t", v, $time);
            end else begin
                e = sbq.pop_front();
                k = v[2] ? 0 : (v[1] ? 1 : 2);
                chk("strobe_slot", 32'(k), 32'(e.slot));
                chk("strobe_value", 32'((k == 0) ? RED_ADC_Value : (k == 1) ? IR_ADC_Value : AMB_ADC_Value),
                    32'(e.val));
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        mon();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_led_red", 32'(LED_RED), 32'd0);
        chk("rst_led_ir",  32'(LED_IR), 32'd0);
        chk("rst_dc",      32'(DC_Comp), 32'd0);
        chk("rst_pga",     32'(PGA_Gain), 32'd0);
        chk("rst_red_val", 32'(RED_ADC_Value), 32'd0);
        chk("rst_ir_val",  32'(IR_ADC_Value), 32'd0);
        chk("rst_amb_val", 32'(AMB_ADC_Value), 32'd0);
        chk("rst_valids",  32'({red_valid, ir_valid, amb_valid}), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
    endtask

    // runs cycles c0..c1 of one slot: checks settings/LEDs/strobe timing, drives ADC
    task automatic run_cyc(input int slot, input int c0, input int c1, input vec_t v,
                           input logic [6:0] edc, input logic [3:0] epga);
        for (int c = c0; c <= c1; c++) begin
            step();
            chk("busy", 32'(busy), 32'd1);
            chk("led_red", 32'(LED_RED), 32'(slot == 0));
            chk("led_ir", 32'(LED_IR), 32'(slot == 1));
            chk("dc_comp", 32'(DC_Comp), 32'(edc));
            chk("pga_gain", 32'(PGA_Gain), 32'(epga));
            chk("valid_timing", 32'({red_valid, ir_valid, amb_valid}),
                32'((c == 8) ? (3'b100 >> slot) : 3'b000));
            ADC = (c < 4) ? v.pre : ((c < 8) ? v.smp[c-4] : v.post);
            if (c == 7) sbq.push_back('{slot, v.exp});
        end
    endtask

    initial begin
        vec_t cv, dv;
        enable      = 1'b0;
        ADC         = 8'd0;
        RED_DC_Comp = 7'd60;
        IR_DC_Comp  = 7'd33;
        RED_PGA     = 4'd5;
        IR_PGA      = 4'd9;

        vecs[0] = mk(0,   200, 200, 200, 200, 0,   200);
        vecs[1] = mk(0,   90,  90,  90,  90,  0,   90);
        vecs[2] = mk(0,   12,  12,  12,  12,  0,   12);
        vecs[3] = mk(0,   10,  20,  30,  41,  0,   25);
        vecs[4] = mk(255, 100, 100, 100, 100, 100, 100);
        vecs[5] = mk(255, 0,   1,   2,   3,   255, 1);
        vecs[6] = mk(0,   255, 255, 255, 255, 0,   255);
        vecs[7] = mk(7,   3,   3,   3,   2,   200, 2);
        vecs[8] = mk(0,   1,   1,   1,   0,   0,   0);

        repeat (2) @(posedge CLK);
        #1;
        chk_reset();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            chk("idle_busy", 32'(busy), 32'd0);
        end

        enable = 1'b1;
        for (int r = 0; r < 9; r++)
            run_cyc(r % 3, 0, 9, vecs[r], (r % 3 == 0) ? 7'd60 : 7'd33, (r % 3 == 0) ? 4'd5 : 4'd9);

        // settings captured only at slot entry
        cv = mk(255, 60, 61, 62, 63, 255, 61);
        run_cyc(0, 0, 5, cv, 7'd60, 4'd5);
        RED_DC_Comp = 7'd70;
        run_cyc(0, 6, 9, cv, 7'd60, 4'd5);
        run_cyc(1, 0, 9, cv, 7'd33, 4'd9);
        run_cyc(2, 0, 9, cv, 7'd33, 4'd9);
        run_cyc(0, 0, 9, cv, 7'd70, 4'd5);

        // enable drop mid-IR: slot and its result complete, then IDLE
        dv = mk(0, 80, 80, 80, 81, 0, 80);
        run_cyc(1, 0, 3, dv, 7'd33, 4'd9);
        enable = 1'b0;
        run_cyc(1, 4, 9, dv, 7'd33, 4'd9);
        repeat (3) begin
            step();
            chk("drop_busy", 32'(busy), 32'd0);
            chk("drop_leds", 32'({LED_RED, LED_IR}), 32'd0);
        end
        chk("drop_dc_hold", 32'(DC_Comp), 32'd33);
        chk("drop_pga_hold", 32'(PGA_Gain), 32'd9);
        chk("hold_red_val", 32'(RED_ADC_Value), 32'd61);
        chk("hold_ir_val", 32'(IR_ADC_Value), 32'd80);
        chk("hold_amb_val", 32'(AMB_ADC_Value), 32'd61);

        // asynchronous reset at RED cnt=6
        enable = 1'b1;
        run_cyc(0, 0, 6, mk(0, 77, 77, 77, 77, 0, 77), 7'd70, 4'd5);
        #2 rst_n = 1'b0;
        #1 chk_reset();
        repeat (2) begin
            step();
            chk_reset();
        end
        rst_n = 1'b1;
        run_cyc(0, 0, 9, mk(0, 40, 40, 40, 40, 0, 40), 7'd70, 4'd5);
        run_cyc(1, 0, 9, mk(9, 1, 2, 3, 4, 9, 2), 7'd33, 4'd9);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
